hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 174 +++++++++++++++++
 tb/tb_hazard_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Hazard controller for a five-stage pipeline: operand forwarding, load-use
// stalls, branch flushes, data-memory wait handling with a timeout error
// state, and saturating performance counters.
module hazard_controller #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        ResultSrcE0,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemErr,
    output logic [15:0] LuStallCnt,
    output logic [15:0] MemWaitCnt,
    output logic [15:0] FlushCnt
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic [7:0] next_wait_cnt;

    logic       lw_stall;
    logic       mem_miss;
    logic       err_active;
    logic       mem_stall;

    // Operand source for one E-stage register: M-stage result beats W-stage.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (rs != 5'd0 && we_m && rs == rd_m)
            return 2'b10;
        else if (rs != 5'd0 && we_w && rs == rd_w)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Forwarding select, independent of stalls and FSM state.
    always_comb begin
        ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

    // Hazard detection and stall/flush outputs; memory stall freezes everything.
    always_comb begin
        lw_stall   = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
        mem_miss   = MemReqM && !MemReadyM;
        // The reset cycle behaves as if the FSM were already back in RUN.
        err_active = (state == ERR) && !reset;
        mem_stall  = mem_miss || err_active;

        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushD = PCSrcE;
            FlushE = lw_stall || PCSrcE;
            FlushW = 1'b0;
        end
    end

    // Memory-wait FSM next state and wait counter.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned; otherwise synthesis infers a latch.
        next_state    = state;
        next_wait_cnt = wait_cnt;
        unique case (state)
            RUN: begin
                if (mem_miss) begin
                    next_state    = WAIT;
                    next_wait_cnt = 8'd1;
                end
            end
            WAIT: begin
                // A dropped request is treated as an abort, ahead of the timeout.
                if (MemReadyM || !MemReqM) begin
                    next_state    = RUN;
                    next_wait_cnt = 8'd0;
                end else if (wait_cnt == MAX_WAIT_C) begin
                    next_state = ERR;
                end else begin
                    next_wait_cnt = wait_cnt + 8'd1;
                end
            end
            ERR: begin
                next_state = ERR;
            end
            default: begin
                next_state    = RUN;
                next_wait_cnt = 8'd0;
            end
        endcase
    end

    // FSM state register and sticky error flag, synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            MemErr   <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait_cnt;
            MemErr   <= (next_state == ERR);
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            LuStallCnt <= 16'd0;
            MemWaitCnt <= 16'd0;
            FlushCnt   <= 16'd0;
        end else begin
            if (lw_stall && !mem_stall)
                LuStallCnt <= sat_inc(LuStallCnt);
            if (mem_stall && !err_active)
                MemWaitCnt <= sat_inc(MemWaitCnt);
            if (PCSrcE && !mem_stall)
                FlushCnt <= sat_inc(FlushCnt);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model.
module tb_hazard_controller;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [15:0] LuStallCnt, MemWaitCnt, FlushCnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: length of the current miss episode, error flag, counters.
    int m_wait;
    bit m_err;
    int m_lu, m_mw, m_fl;

    always #5 clk = ~clk;

    hazard_controller #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
        .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
        .LuStallCnt(LuStallCnt), .MemWaitCnt(MemWaitCnt), .FlushCnt(FlushCnt)
    );

    task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input int rs, input int rd_m, input bit we_m,
                                           input int rd_w, input bit we_w);
        if (rs != 0 && we_m && rs == rd_m) return 2'b10;
        if (rs != 0 && we_w && rs == rd_w) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_lw();
        return ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    endfunction

    function automatic bit ref_ms();
        return (MemReqM && !MemReadyM) || (m_err && !reset);
    endfunction

    function automatic int inc_sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Compare every output with the model for the current inputs.
    task automatic compare_all();
        bit lw = ref_lw();
        bit ms = ref_ms();
        check("ForwardAE", 16'(ForwardAE), 16'(ref_fwd(Rs1E, RdM, RegWriteM, RdW, RegWriteW)));
        check("ForwardBE", 16'(ForwardBE), 16'(ref_fwd(Rs2E, RdM, RegWriteM, RdW, RegWriteW)));
        check("StallF", 16'(StallF), 16'(ms || lw));
        check("StallD", 16'(StallD), 16'(ms || lw));
        check("StallE", 16'(StallE), 16'(ms));
        check("StallM", 16'(StallM), 16'(ms));
        check("FlushD", 16'(FlushD), 16'(!ms && PCSrcE));
        check("FlushE", 16'(FlushE), 16'(!ms && (lw || PCSrcE)));
        check("FlushW", 16'(FlushW), 16'(ms));
        check("MemErr", 16'(MemErr), 16'(m_err));
        check("LuStallCnt", LuStallCnt, 16'(m_lu));
        check("MemWaitCnt", MemWaitCnt, 16'(m_mw));
        check("FlushCnt", FlushCnt, 16'(m_fl));
    endtask

    // Advance the model across a rising edge using the inputs held over it.
    task automatic model_update();
        bit lw = ref_lw();
        bit ms = ref_ms();
        bit miss = MemReqM && !MemReadyM;
        if (reset) begin
            m_wait = 0; m_err = 0; m_lu = 0; m_mw = 0; m_fl = 0;
        end else begin
            if (lw && !ms) m_lu = inc_sat(m_lu);
            if (ms && !m_err) m_mw = inc_sat(m_mw);
            if (PCSrcE && !ms) m_fl = inc_sat(m_fl);
            if (!m_err) begin
                if (m_wait == 0) begin
                    if (miss) m_wait = 1;
                end else if (!miss) begin
                    m_wait = 0;
                end else if (m_wait == MAX_WAIT) begin
                    m_err = 1;
                end else begin
                    m_wait++;
                end
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic idle_inputs();
        reset = 0;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    initial begin
        m_wait = 0; m_err = 0; m_lu = 0; m_mw = 0; m_fl = 0;
        idle_inputs();
        reset = 1;
        // The first edge establishes the known reset state; outputs are
        // compared from the following cycle on.
        advance();
        reset = 0;

        // Reset state.
        settle();
        check("rst_memerr", 16'(MemErr), 16'd0);
        check("rst_lu", LuStallCnt, 16'd0);
        check("rst_stallf", 16'(StallF), 16'd0);
        advance();

        // Forwarding priority.
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        settle(); check("fwd_m", 16'(ForwardAE), 16'h2); advance();
        RegWriteM = 0;
        settle(); check("fwd_w", 16'(ForwardAE), 16'h1); advance();
        Rs1E = 0;
        settle(); check("fwd_zero", 16'(ForwardAE), 16'h0); advance();

        // Load-use stall.
        do_reset();
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        settle();
        check("lu_stallf", 16'(StallF), 16'd1);
        check("lu_stalld", 16'(StallD), 16'd1);
        check("lu_flushe", 16'(FlushE), 16'd1);
        check("lu_flushd", 16'(FlushD), 16'd0);
        advance();
        RdE = 0;
        settle();
        check("lu_cnt", LuStallCnt, 16'd1);
        check("lu_r0_nostall", 16'(StallF), 16'd0);
        advance();

        // Branch flush.
        do_reset();
        PCSrcE = 1;
        settle();
        check("br_flushd", 16'(FlushD), 16'd1);
        check("br_flushe", 16'(FlushE), 16'd1);
        check("br_stallf", 16'(StallF), 16'd0);
        advance();
        PCSrcE = 0;
        settle(); check("br_cnt", FlushCnt, 16'd1); advance();

        // Memory wait of three cycles with a branch pending.
        do_reset();
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("mw_stallm", 16'(StallM), 16'd1);
            check("mw_flushw", 16'(FlushW), 16'd1);
            check("mw_flushd", 16'(FlushD), 16'd0);
            advance();
        end
        MemReadyM = 1;
        settle();
        check("mw_ready_stallf", 16'(StallF), 16'd0);
        check("mw_ready_flushd", 16'(FlushD), 16'd1);
        advance();
        MemReqM = 0; MemReadyM = 0; PCSrcE = 0;
        settle();
        check("mw_cnt", MemWaitCnt, 16'd3);
        check("mw_back_run", 16'(StallE), 16'd0);
        advance();

        // Timeout into ERR.
        do_reset();
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 1 + MAX_WAIT; i++) begin
            settle();
            check("to_memerr_low", 16'(MemErr), 16'd0);
            advance();
        end
        settle();
        check("to_memerr", 16'(MemErr), 16'd1);
        check("to_stalle", 16'(StallE), 16'd1);
        advance();
        MemReadyM = 1;
        cycle();
        MemReqM = 0;
        settle();
        check("to_absorb", 16'(MemErr), 16'd1);
        check("to_absorb_stall", 16'(StallF), 16'd1);
        advance();
        reset = 1;
        settle(); check("to_rst_stall", 16'(StallF), 16'd0); advance();
        reset = 0; MemReadyM = 0;
        settle();
        check("to_rst_memerr", 16'(MemErr), 16'd0);
        check("to_rst_mw", MemWaitCnt, 16'd0);
        check("to_rst_fl", FlushCnt, 16'd0);
        advance();

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            Rs1D        = 5'($urandom_range(0, 3));
            Rs2D        = 5'($urandom_range(0, 3));
            Rs1E        = 5'($urandom_range(0, 3));
            Rs2E        = 5'($urandom_range(0, 3));
            RdE         = 5'($urandom_range(0, 3));
            RdM         = 5'($urandom_range(0, 3));
            RdW         = 5'($urandom_range(0, 3));
            RegWriteM   = 1'($urandom);
            RegWriteW   = 1'($urandom);
            ResultSrcE0 = 1'($urandom);
            PCSrcE      = ($urandom_range(0, 3) == 0);
            MemReqM     = 1'($urandom);
            MemReadyM   = ($urandom_range(0, 2) == 0);
            cycle();
        end

        // Saturation of the load-use counter.
        do_reset();
        ResultSrcE0 = 1; RdE = 7; Rs1D = 7;
        for (int i = 0; i < 65540; i++) cycle();
        settle();
        check("sat_lu", LuStallCnt, 16'hFFFF);
        advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
